// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: iterative radix-2 shift-and-add multiplier around one adder.
// Optional signed support (isSigned port, FIXUP state) is enabled by defining SEQ_MUL_SIGNED_EN.
module adder #(
    parameter int    GATE_DELAY = 50,
    parameter int    BIT_WIDTH  = 64,
    parameter string METHOD     = "RTL"
) (
    input  logic [BIT_WIDTH-1:0] in1,
    input  logic [BIT_WIDTH-1:0] in2,
    input  logic                 cIn,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 cOut
);
    // GATE_DELAY only matters to timing models; a negative value selects the behavioural adder
    if (METHOD == "RIPPLECARRY" && GATE_DELAY >= 0) begin : g_ripple
        logic [BIT_WIDTH:0] c;
        assign c[0] = cIn;
        for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_bit
            assign sum[i]   = in1[i] ^ in2[i] ^ c[i];
            assign c[i + 1] = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
        end
        assign cOut = c[BIT_WIDTH];
    end else begin : g_rtl
        assign {cOut, sum} = {1'b0, in1} + {1'b0, in2} + {{BIT_WIDTH{1'b0}}, cIn};
    end
endmodule

module seq_shift_add_multiplier #(
    parameter int    GATE_DELAY = 50,
    parameter int    BIT_WIDTH  = 64,
    parameter string ADD_METHOD = "RTL"
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [BIT_WIDTH-1:0]   multiplicand,
    input  logic [BIT_WIDTH-1:0]   multiplier,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic                   isSigned,
`endif
    output logic                   outValid,
    input  logic                   outReady,
    output logic [2*BIT_WIDTH-1:0] product,
    output logic                   busy
);
    localparam int CW = $clog2(BIT_WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
`ifdef SEQ_MUL_SIGNED_EN
    localparam logic [1:0] FIXUP = 2'd3;
`endif
    logic [1:0]           state;
    logic [BIT_WIDTH-1:0] acc_hi, acc_lo, mcand, addend, sum, op_a, op_b;
    logic                 c_out, last;
    logic [CW-1:0]        count;
`ifdef SEQ_MUL_SIGNED_EN
    logic neg_flag;
    // magnitudes fit unsigned, so the most-negative operand needs no special case
    assign op_a = (isSigned && multiplicand[BIT_WIDTH-1]) ? -multiplicand : multiplicand;
    assign op_b = (isSigned && multiplier[BIT_WIDTH-1]) ? -multiplier : multiplier;
`else
    assign op_a = multiplicand;
    assign op_b = multiplier;
`endif
    assign addend   = acc_lo[0] ? mcand : '0;
    assign last     = count == CW'(BIT_WIDTH - 1);
    assign inReady  = state == IDLE;
    assign outValid = state == DONE;
    assign busy     = state != IDLE;
    assign product  = {acc_hi, acc_lo};

    adder #(.GATE_DELAY(GATE_DELAY), .BIT_WIDTH(BIT_WIDTH), .METHOD(ADD_METHOD)) u_adder (
        .in1(acc_hi), .in2(addend), .cIn(1'b0), .sum(sum), .cOut(c_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            count  <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            neg_flag <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (inValid) begin
                    mcand  <= op_a;
                    acc_lo <= op_b;
                    acc_hi <= '0;
                    count  <= '0;
`ifdef SEQ_MUL_SIGNED_EN
                    neg_flag <= isSigned & (multiplicand[BIT_WIDTH-1] ^ multiplier[BIT_WIDTH-1]);
`endif
                    state  <= BUSY;
                end
                BUSY: begin
                    // carry-out becomes the new top bit as the accumulator shifts right
                    {acc_hi, acc_lo} <= {c_out, sum, acc_lo[BIT_WIDTH-1:1]};
                    count <= count + 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
                    if (last) state <= FIXUP;
`else
                    if (last) state <= DONE;
`endif
                end
`ifdef SEQ_MUL_SIGNED_EN
                FIXUP: begin
                    if (neg_flag) {acc_hi, acc_lo} <= -{acc_hi, acc_lo};
                    state <= DONE;
                end
`endif
                DONE: if (outReady) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: scoreboard bench for the 8-bit multiplier, unsigned or signed build.
module tb_seq_shift_add_multiplier;
    localparam int N = 8;
`ifdef SEQ_MUL_SIGNED_EN
    localparam int LAT = N + 1;
`else
    localparam int LAT = N;
`endif
    logic           clk = 1'b0;
    logic           reset, in_valid, out_ready, is_signed;
    logic [N-1:0]   multiplicand, multiplier;
    logic           in_ready, out_valid, busy;
    logic [2*N-1:0] product;
    logic [2*N-1:0] sb[$];
    int             errors = 0;
    int             checks = 0;

    seq_shift_add_multiplier #(.GATE_DELAY(50), .BIT_WIDTH(N), .ADD_METHOD("RIPPLECARRY")) dut (
        .clk(clk), .reset(reset), .inValid(in_valid), .inReady(in_ready),
        .multiplicand(multiplicand), .multiplier(multiplier),
`ifdef SEQ_MUL_SIGNED_EN
        .isSigned(is_signed),
`endif
        .outValid(out_valid), .outReady(out_ready), .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input int hold);
        logic [2*N-1:0] e;
        int cyc;
        e = s ? {{N{a[N-1]}}, a} * {{N{b[N-1]}}, b} : {{N{1'b0}}, a} * {{N{1'b0}}, b};
        check("accept_ready", in_ready, 1);
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        in_valid     = 1'b1;
        out_ready    = hold == 0;
        sb.push_back(e);
        step();
        in_valid     = 1'b0;
        multiplicand = N'($urandom);
        multiplier   = N'($urandom);
        is_signed    = ~s;
        check("busy", busy, 1);
        check("busy_in_ready", in_ready, 0);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
        check("latency", cyc, LAT);
        check("done_busy", busy, 1);
        check("product", product, sb.pop_front());
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", out_valid, 1);
            check("hold_product", product, e);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    initial begin
        int rises;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; is_signed = 1'b0;
        multiplicand = '0; multiplier = '0;
        repeat (2) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_product", product, 0);
        reset = 1'b0;
        run_op(8'd13, 8'd11, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b0, 0);
        run_op(8'h00, 8'hA5, 1'b0, 0);
        run_op(8'hA5, 8'h00, 1'b0, 0);
        run_op(8'd7, 8'd6, 1'b0, 5);
        // reset in the middle of an operation must discard it
        check("abort_ready", in_ready, 1);
        multiplicand = 8'd9; multiplier = 8'd9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_product", product, 0);
        rises = 0;
        repeat (12) begin
            step();
            if (out_valid) rises++;
        end
        check("abort_no_valid", rises, 0);
        run_op(8'd2, 8'd3, 1'b0, 0);
`ifdef SEQ_MUL_SIGNED_EN
        run_op(8'hFD, 8'd5, 1'b1, 0);
        run_op(8'h80, 8'h80, 1'b1, 0);
        run_op(8'hFD, 8'd5, 1'b0, 0);
        repeat (4) run_op(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
`else
        repeat (4) run_op(N'($urandom), N'($urandom), 1'b0, int'($urandom_range(0, 2)));
`endif
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
